// File: rtl/axi_lite_cmd_master.sv
// ============================================================================
// Module  : axi_lite_cmd_master
// Purpose : Single-beat command stream to AXI4-lite read/write initiator with
//           independent AW/W handling, response pulse and transaction timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_cmd_master #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              areset,
  output logic [AW-1:0]     mmr_awaddr,
  output logic [2:0]        mmr_awprot,
  output logic              mmr_awvalid,
  input  logic              mmr_awready,
  output logic [DW-1:0]     mmr_wdata,
  output logic [DW/8-1:0]   mmr_wstrb,
  output logic              mmr_wvalid,
  input  logic              mmr_wready,
  input  logic              mmr_bvalid,
  input  logic [1:0]        mmr_bresp,
  output logic              mmr_bready,
  output logic [AW-1:0]     mmr_araddr,
  output logic [2:0]        mmr_arprot,
  output logic              mmr_arvalid,
  input  logic              mmr_arready,
  input  logic              mmr_rvalid,
  input  logic [DW-1:0]     mmr_rdata,
  input  logic [1:0]        mmr_rresp,
  output logic              mmr_rready,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [DW/8-1:0]   cmd_wstrb,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;

  // Counter value seen on the edge that is TIMEOUT_CYC edges after accept.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state, state_nxt;
  logic             run;
  logic             aw_done, w_done;
  logic [CNT_W-1:0] to_cnt;
  logic             accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             wr_addr_done, rsp_done, timeout;

  assign mmr_awprot = 3'b000;
  assign mmr_arprot = 3'b000;

  assign accept       = cmd_valid && cmd_ready;
  assign aw_hs        = mmr_awvalid && mmr_awready;
  assign w_hs         = mmr_wvalid && mmr_wready;
  assign b_hs         = mmr_bvalid && mmr_bready;
  assign ar_hs        = mmr_arvalid && mmr_arready;
  assign r_hs         = mmr_rvalid && mmr_rready;
  assign wr_addr_done = (aw_done || aw_hs) && (w_done || w_hs);
  assign rsp_done     = ((state == S_WR_RESP) && b_hs) || ((state == S_RD_DATA) && r_hs);
  // A genuine response on the expiry edge wins over the forced error.
  assign timeout      = (TIMEOUT_CYC != 0) && busy && (to_cnt == TO_LAST) && !rsp_done;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept)       state_nxt = cmd_write ? S_WR : S_RD_ADDR;
      S_WR:      if (wr_addr_done) state_nxt = S_WR_RESP;
      S_WR_RESP: if (b_hs)         state_nxt = S_IDLE;
      S_RD_ADDR: if (ar_hs)        state_nxt = S_RD_DATA;
      S_RD_DATA: if (r_hs)         state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  // run keeps cmd_ready low until the first edge after reset release.
  always_comb begin
    cmd_ready = run && (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      run         <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      to_cnt      <= '0;
      mmr_awaddr  <= '0;
      mmr_awvalid <= 1'b0;
      mmr_wdata   <= '0;
      mmr_wstrb   <= '0;
      mmr_wvalid  <= 1'b0;
      mmr_bready  <= 1'b0;
      mmr_araddr  <= '0;
      mmr_arvalid <= 1'b0;
      mmr_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      run       <= 1'b1;
      rsp_valid <= 1'b0;
      if (rsp_valid && (rsp_resp != 2'b00) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (busy) to_cnt <= to_cnt + 1'b1;
      if (accept) begin
        to_cnt  <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cmd_write) begin
          mmr_awaddr  <= cmd_addr;
          mmr_wdata   <= cmd_wdata;
          mmr_wstrb   <= cmd_wstrb;
          mmr_awvalid <= 1'b1;
          mmr_wvalid  <= 1'b1;
        end else begin
          mmr_araddr  <= cmd_addr;
          mmr_arvalid <= 1'b1;
        end
      end
      if (aw_hs) begin
        mmr_awvalid <= 1'b0;
        aw_done     <= 1'b1;
      end
      if (w_hs) begin
        mmr_wvalid <= 1'b0;
        w_done     <= 1'b1;
      end
      if ((state == S_WR) && wr_addr_done) mmr_bready <= 1'b1;
      if (b_hs) mmr_bready <= 1'b0;
      if (ar_hs) begin
        mmr_arvalid <= 1'b0;
        mmr_rready  <= 1'b1;
      end
      if (r_hs) mmr_rready <= 1'b0;
      if (rsp_done) begin
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b0;
        rsp_resp    <= (state == S_RD_DATA) ? mmr_rresp : mmr_bresp;
        rsp_rdata   <= (state == S_RD_DATA) ? mmr_rdata : '0;
      end else if (timeout) begin
        mmr_awvalid <= 1'b0;
        mmr_wvalid  <= 1'b0;
        mmr_bready  <= 1'b0;
        mmr_arvalid <= 1'b0;
        mmr_rready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
// ============================================================================
// Module  : tb_axi_lite_cmd_master
// Purpose : Scoreboard bench for axi_lite_cmd_master with a delay-programmable
//           AXI4-lite slave model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic areset;
  logic [AW-1:0] mmr_awaddr, mmr_araddr, cmd_addr;
  logic [2:0] mmr_awprot, mmr_arprot;
  logic mmr_awvalid, mmr_awready, mmr_wvalid, mmr_wready, mmr_bvalid, mmr_bready;
  logic mmr_arvalid, mmr_arready, mmr_rvalid, mmr_rready;
  logic [DW-1:0] mmr_wdata, mmr_rdata, cmd_wdata, rsp_rdata;
  logic [DW/8-1:0] mmr_wstrb, cmd_wstrb;
  logic [1:0] mmr_bresp, mmr_rresp, rsp_resp;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_timeout, busy;
  logic [CW-1:0] err_cnt;

  axi_lite_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .areset(areset),
    .mmr_awaddr(mmr_awaddr), .mmr_awprot(mmr_awprot), .mmr_awvalid(mmr_awvalid), .mmr_awready(mmr_awready),
    .mmr_wdata(mmr_wdata), .mmr_wstrb(mmr_wstrb), .mmr_wvalid(mmr_wvalid), .mmr_wready(mmr_wready),
    .mmr_bvalid(mmr_bvalid), .mmr_bresp(mmr_bresp), .mmr_bready(mmr_bready),
    .mmr_araddr(mmr_araddr), .mmr_arprot(mmr_arprot), .mmr_arvalid(mmr_arvalid), .mmr_arready(mmr_arready),
    .mmr_rvalid(mmr_rvalid), .mmr_rdata(mmr_rdata), .mmr_rresp(mmr_rresp), .mmr_rready(mmr_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Slave behaviour: a ready/valid is raised once the master side has been
  // waiting this many cycles; -1 means never respond.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] last_aw = '0, last_ar = '0;
  logic [31:0] txn_addr = '0, txn_data = '0;
  logic [3:0]  txn_strb = '0;
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_hs_n = 0, r_hs_n = 0, rsp_n = 0;
  int exp_err = 0;
  int rsp_target = 0;
  bit chk_rdy = 1'b0;
  bit prev_rsp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave model and response monitor, both evaluated at the falling edge.
  initial begin
    exp_t e;
    mmr_awready = 0; mmr_wready = 0; mmr_arready = 0;
    mmr_bvalid = 0; mmr_bresp = 0; mmr_rvalid = 0; mmr_rdata = 0; mmr_rresp = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        mmr_awready = 0; mmr_wready = 0; mmr_arready = 0; mmr_bvalid = 0; mmr_rvalid = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; prev_rsp = 0;
        continue;
      end
      if (mmr_awvalid) begin mmr_awready = (aw_dly >= 0 && aw_c >= aw_dly); aw_c++; end
      else begin mmr_awready = 0; aw_c = 0; end
      if (mmr_wvalid) begin mmr_wready = (w_dly >= 0 && w_c >= w_dly); w_c++; end
      else begin mmr_wready = 0; w_c = 0; end
      if (mmr_arvalid) begin mmr_arready = (ar_dly >= 0 && ar_c >= ar_dly); ar_c++; end
      else begin mmr_arready = 0; ar_c = 0; end
      if (mmr_bready) begin mmr_bvalid = (b_dly >= 0 && b_c >= b_dly); mmr_bresp = last_aw[9:8]; b_c++; end
      else begin mmr_bvalid = 0; b_c = 0; end
      if (mmr_rready) begin
        mmr_rvalid = (r_dly >= 0 && r_c >= r_dly); mmr_rdata = rd_val; mmr_rresp = last_ar[9:8]; r_c++;
      end else begin mmr_rvalid = 0; mmr_rdata = 0; r_c = 0; end

      if (mmr_awvalid && mmr_awready) begin
        aw_hs_n++; last_aw = mmr_awaddr;
        check("awaddr", mmr_awaddr, txn_addr);
      end
      if (mmr_wvalid && mmr_wready) begin
        w_hs_n++;
        check("wdata", mmr_wdata, txn_data);
        check("wstrb", mmr_wstrb, txn_strb);
      end
      if (mmr_arvalid && mmr_arready) begin
        ar_hs_n++; last_ar = mmr_araddr;
        check("araddr", mmr_araddr, txn_addr);
      end
      if (mmr_bvalid && mmr_bready) b_hs_n++;
      if (mmr_rvalid && mmr_rready) r_hs_n++;
      if (mmr_bready) check("bready_excl", {mmr_awvalid, mmr_wvalid, mmr_arvalid, mmr_rready}, 4'b0);
      if (chk_rdy) check("ready_vs_busy", cmd_ready, !busy);

      if (rsp_valid) begin
        rsp_n++;
        check("rsp_pulse_len", prev_rsp, 0);
        check("ready_in_rsp", cmd_ready, 1);
        if (sbq.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          e = sbq.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
          check("rsp_timeout", rsp_timeout, e.to);
          if (e.lat > 0) check("rsp_latency", cyc - e.acc, e.lat);
          if (e.resp != 2'b00) exp_err++;
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  // Presents a command and leaves cmd_valid high; lat is cycles counted from
  // the falling edge before the accept edge to the response cycle (0 = skip).
  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit exp_to, input int lat);
    exp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      e.to    = exp_to;
      e.resp  = exp_to ? 2'b10 : addr[9:8];
      e.rdata = (exp_to || wr) ? 32'h0 : rd_val;
      e.acc   = cyc;
      e.lat   = lat;
      sbq.push_back(e);
      rsp_target++;
      txn_addr = addr; txn_data = data; txn_strb = strb;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 400 && rsp_n < rsp_target; i++) @(negedge clk);
    check("rsp_count", rsp_n, rsp_target);
    repeat (3) @(negedge clk);
    check("err_cnt", err_cnt, exp_err);
  endtask

  task automatic clr_counts();
    aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; b_hs_n = 0; r_hs_n = 0;
  endtask

  initial begin
    int snap;
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {mmr_awvalid, mmr_wvalid, mmr_arvalid, mmr_bready, mmr_rready}, 5'b0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b0);
    check("rst_err_cnt", err_cnt, 0);
    areset = 0; #1;
    check("ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", cmd_ready, 1);
    chk_rdy = 1;

    // Zero-wait write, AW and W handshake together.
    clr_counts();
    send(1, 32'h10, 32'h15, 4'hF, 0, 3); cmd_valid = 0;
    wait_rsp();
    check("t1_aw_hs", aw_hs_n, 1); check("t1_w_hs", w_hs_n, 1); check("t1_b_hs", b_hs_n, 1);

    // AW ready after 1 cycle, W ready after 4 cycles.
    clr_counts(); aw_dly = 1; w_dly = 4;
    send(1, 32'h04, 32'hFF, 4'h1, 0, 7); cmd_valid = 0;
    wait_rsp();
    check("t2_aw_hs", aw_hs_n, 1); check("t2_w_hs", w_hs_n, 1); check("t2_b_hs", b_hs_n, 1);
    aw_dly = 0; w_dly = 0;

    // Read with 3-cycle rvalid delay.
    clr_counts(); r_dly = 3; rd_val = 32'h0000_0001;
    send(0, 32'h00, 32'h0, 4'h0, 0, 6); cmd_valid = 0;
    wait_rsp();
    check("t3_ar_hs", ar_hs_n, 1); check("t3_r_hs", r_hs_n, 1);
    r_dly = 0;

    // Slave never accepts AR: forced error 16 edges after accept.
    clr_counts(); ar_dly = -1;
    send(0, 32'h20, 32'h0, 4'h0, 1, TO + 1); cmd_valid = 0;
    wait_rsp();
    check("t4_arvalid_low", mmr_arvalid, 0);
    check("t4_ar_hs", ar_hs_n, 0);
    ar_dly = 0; rd_val = 32'hA5A5_0033;
    send(0, 32'h30, 32'h0, 4'h0, 0, 3); cmd_valid = 0;
    wait_rsp();

    // Back-to-back: cmd_valid held across three writes and a read.
    clr_counts(); rd_val = 32'h0000_0005;
    send(1, 32'h100, 32'h11, 4'hF, 0, 3);
    send(1, 32'h200, 32'h22, 4'h3, 0, 3);
    send(1, 32'h300, 32'h33, 4'hC, 0, 3);
    send(0, 32'h000, 32'h0, 4'h0, 0, 3);
    cmd_valid = 0;
    wait_rsp();
    check("t5_aw_hs", aw_hs_n, 3); check("t5_ar_hs", ar_hs_n, 1);

    // Reset while waiting for B.
    b_dly = -1;
    send(1, 32'h40, 32'h77, 4'hF, 0, 0); cmd_valid = 0;
    for (int i = 0; i < 50 && !mmr_bready; i++) @(negedge clk);
    check("t6_in_wr_resp", mmr_bready, 1);
    chk_rdy = 0; snap = rsp_n;
    #2 areset = 1; #1;
    check("t6_valids", {mmr_awvalid, mmr_wvalid, mmr_arvalid, mmr_bready, mmr_rready}, 5'b0);
    check("t6_payload", {mmr_awaddr, mmr_wdata}, 64'h0);
    check("t6_wstrb_araddr", {mmr_wstrb, mmr_araddr}, 36'h0);
    check("t6_ready_busy", {cmd_ready, busy}, 2'b00);
    check("t6_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 36'h0);
    check("t6_err_cnt", err_cnt, 0);
    sbq.delete(); rsp_target = snap; exp_err = 0; b_dly = 0;
    @(negedge clk); areset = 0; #1;
    check("t6_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("t6_ready_after_edge", cmd_ready, 1);
    chk_rdy = 1;
    repeat (3) @(negedge clk);
    check("t6_no_rsp", rsp_n, snap);
    send(1, 32'h50, 32'h9, 4'hF, 0, 3); cmd_valid = 0;
    wait_rsp();
    check("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
